key_schedule_engine: RTL and testbench
======================================

# key_schedule_engine

Sequential, parametrised AES key schedule generating every round key for AES-128/192/256 from one cipher key, one 32-bit word per clock, using four shared SBox instances. Results land in an internal round-key store and are read back through an indexed 128-bit port. It replaces the fully unrolled combinational expander in the AES datapath where area matters more than key-change latency.

## Interface
- KEY_BITS, 128, cipher key length; legal values 128, 192, 256 (Nk = KEY_BITS/32, Nr = Nk+6, T = 4*(Nr+1) words: 44/52/60)
- clk  input  1  rising-edge clock
- resetN  input  1  synchronous, active-low reset
- startValid  input  1  request to expand keyIn
- startReady  output  1  high while idle; a transfer occurs on an edge with startValid && startReady
- keyIn  input  KEY_BITS  cipher key; word 0 is keyIn[KEY_BITS-1 -: 32]
- busy  output  1  expansion in progress
- done  output  1  one-cycle pulse when the last word has been written
- keyReady  output  1  store holds a complete, valid schedule
- roundIndex  input  4  round key to read, 0..Nr
- roundKeyOut  output  128  words 4r..4r+3 of the store, word 4r in [127:96]

## Operation
- States: IDLE, EXPAND. startReady = (state == IDLE); busy = (state == EXPAND).
- IDLE: on transfer, write keyIn words to store[0..Nk-1] and to an Nk-word sliding window, set i = Nk, rcon = 8'h01, clear keyReady, go EXPAND. Without transfer, hold.
- EXPAND: each edge writes store[i] = w[i-Nk] ^ temp, temp from w[i-1]:
  - i mod Nk == 0: SubWord(RotWord(temp)) ^ {rcon, 24'h0}; rcon then updated by xtime (01,02,04,…,80,1b,36).
  - Nk == 8 and i mod Nk == 4: SubWord(temp).
  - otherwise temp unchanged.
- Window shifts by one word per edge; i mod Nk tracked by a separate counter (no divider).
- On the edge writing store[T-1]: state → IDLE, done = 1 for exactly the following cycle, keyReady = 1.
- startValid while busy is ignored (startReady low); keyIn only sampled on the transfer edge.
- roundKeyOut is combinational from roundIndex and the store; roundIndex > Nr returns 128'h0.
- Reset (any state, incl. mid-expansion): state IDLE, store cleared to zero, i/rcon cleared, done = 0, keyReady = 0. Partial schedule is discarded.

## Timing
- Reset values after reset edge: startReady 1, busy 0, done 0, keyReady 0, roundKeyOut 128'h0.
- Accept edge E0; expansion edges E1..E(T-Nk): 40 (AES-128), 46 (AES-192), 52 (AES-256).
- done and keyReady visible in the cycle after E(T-Nk); startReady rises the same cycle, so a back-to-back start may transfer on the very next edge (done and the new transfer coincide; keyReady then clears on that edge).
- store[0..Nk-1] readable in the cycle after E0; store[k] readable in the cycle after its write edge.
- Round-key read latency: zero cycles (combinational).

## Configuration
- KEY_SCHED_READ_GUARD_EN defined: roundKeyOut forced to 128'h0 whenever keyReady == 0 (including during EXPAND and after reset), so no partial or stale schedule is ever exposed.
- Undefined: roundKeyOut always reflects raw store contents; during a re-expansion earlier rounds show new words while later rounds still hold the previous schedule.

## Test plan
- AES-128, keyIn 2b7e151628aed2a6abf7158809cf4f3c -> done exactly 40 edges after accept; roundIndex 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6, roundIndex 0 reads keyIn.
- AES-192 build, keyIn 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 edges; roundIndex 12 reads e98ba06f448c773c8ecc720401002202; roundIndex 13 reads 0.
- AES-256 build, keyIn 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 edges; roundIndex 14 reads fe4890d1e6188d0b046df344706c631e.
- Reset low at edge 20 of an AES-128 expansion -> busy 0, keyReady 0, roundKeyOut 0 for all indices; fresh start then completes in 40 edges with correct keys.
- startValid held high throughout with changing keyIn -> only keys present on accept edges used; back-to-back second transfer on the edge after done; startValid during busy has no effect.
- Guard check: with KEY_SCHED_READ_GUARD_EN, read roundIndex 1 mid-expansion -> 0; without it -> a0fafe1788542cb123a339392a6c7605 once store[4..7] are written.

Source files
------------

// File: rtl/key_schedule_engine.sv
// Purpose : sequential AES-128/192/256 key expander; one 32-bit schedule word per clock into an internal round-key store.
// Latency : accept edge plus T-Nk expansion edges (40/46/52); round-key reads are combinational (zero cycles).
// Backpr. : startReady low while expanding; startValid is ignored until the engine returns to idle.
//
// Ports:
//   clk, resetN              rising-edge clock, synchronous active-low reset
//   startValid/startReady    handshake for a new cipher key (keyIn sampled on the transfer edge only)
//   keyIn[KEY_BITS]          cipher key, word 0 in the top 32 bits
//   busy, done, keyReady     expansion in progress, one-cycle completion pulse, store holds a full schedule
//   roundIndex[4]            round key to read (0..Nr); larger indices read as zero
//   roundKeyOut[128]         words 4r..4r+3 of the store, word 4r in [127:96]
// Optional feature: define KEY_SCHED_READ_GUARD_EN to force roundKeyOut to zero while keyReady is low.

module key_schedule_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];
endmodule

module key_schedule_engine #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startValid,
  output logic                startReady,
  input  logic [KEY_BITS-1:0] keyIn,
  output logic                busy,
  output logic                done,
  output logic                keyReady,
  input  logic [3:0]          roundIndex,
  output logic [127:0]        roundKeyOut
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] store_q [NW];
  logic [31:0] store_d [NW];
  // Sliding window of the last NK words: win_q[0] = w[i-NK], win_q[NK-1] = w[i-1].
  logic [31:0] win_q [NK];
  logic [31:0] win_d [NK];
  logic [5:0]  i_q, i_d;
  // i mod NK, tracked incrementally so no divider is needed.
  logic [2:0]  mod_q, mod_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        done_q, done_d;
  logic        key_ready_q, key_ready_d;

  logic [31:0] temp, sub_in, sub_out, temp_x, new_word;

  assign temp   = win_q[NK-1];
  // RotWord only on the rcon step; the AES-256 mid-key step substitutes without rotation.
  assign sub_in = (mod_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    key_schedule_sbox u_sbox (
      .in_byte  (sub_in[8*g +: 8]),
      .out_byte (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    temp_x = temp;
    if (mod_q == 3'd0) begin
      temp_x = sub_out ^ {rcon_q, 24'h0};
    end else if ((NK == 8) && (mod_q == 3'd4)) begin
      temp_x = sub_out;
    end
  end

  assign new_word = win_q[0] ^ temp_x;

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    win_d       = win_q;
    i_d         = i_q;
    mod_d       = mod_q;
    rcon_d      = rcon_q;
    done_d      = 1'b0;
    key_ready_d = key_ready_q;
    case (state_q)
      IDLE: begin
        if (startValid) begin
          for (int j = 0; j < NK; j++) begin
            store_d[j] = keyIn[KEY_BITS-1-32*j -: 32];
            win_d[j]   = keyIn[KEY_BITS-1-32*j -: 32];
          end
          i_d         = 6'(NK);
          mod_d       = 3'd0;
          rcon_d      = 8'h01;
          key_ready_d = 1'b0;
          state_d     = EXPAND;
        end
      end
      default: begin
        store_d[i_q] = new_word;
        for (int j = 0; j < NK - 1; j++) begin
          win_d[j] = win_q[j+1];
        end
        win_d[NK-1] = new_word;
        i_d         = i_q + 6'd1;
        mod_d       = (mod_q == 3'(NK - 1)) ? 3'd0 : mod_q + 3'd1;
        if (mod_q == 3'd0) begin
          // xtime: multiply by x in GF(2^8) modulo the AES polynomial.
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        if (i_q == 6'(NW - 1)) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          key_ready_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      for (int j = 0; j < NW; j++) begin
        store_q[j] <= '0;
      end
      for (int j = 0; j < NK; j++) begin
        win_q[j] <= '0;
      end
      i_q         <= '0;
      mod_q       <= '0;
      rcon_q      <= '0;
      done_q      <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      win_q       <= win_d;
      i_q         <= i_d;
      mod_q       <= mod_d;
      rcon_q      <= rcon_d;
      done_q      <= done_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign startReady = (state_q == IDLE);
  assign busy       = (state_q == EXPAND);
  assign done       = done_q;
  assign keyReady   = key_ready_q;

  logic [5:0]   rk_base;
  logic [127:0] rk_raw;

  assign rk_base = {roundIndex, 2'b00};

  always_comb begin
    rk_raw = '0;
    if (roundIndex <= 4'(NR)) begin
      rk_raw = {store_q[rk_base], store_q[rk_base + 6'd1],
                store_q[rk_base + 6'd2], store_q[rk_base + 6'd3]};
    end
  end

`ifdef KEY_SCHED_READ_GUARD_EN
  // Never expose a partial or stale schedule.
  assign roundKeyOut = key_ready_q ? rk_raw : 128'h0;
`else
  assign roundKeyOut = rk_raw;
`endif

endmodule

// File: tb/tb_key_schedule_engine.sv
module tb_key_schedule_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetN;
  logic         sv  [3];
  logic         sr  [3];
  logic         bz  [3];
  logic         dn  [3];
  logic         kr  [3];
  logic [255:0] kin [3];
  logic [3:0]   ri  [3];
  logic [127:0] rko [3];

  key_schedule_engine #(.KEY_BITS(128)) u_aes128 (
    .clk(clk), .resetN(resetN), .startValid(sv[0]), .startReady(sr[0]), .keyIn(kin[0][127:0]),
    .busy(bz[0]), .done(dn[0]), .keyReady(kr[0]), .roundIndex(ri[0]), .roundKeyOut(rko[0]));
  key_schedule_engine #(.KEY_BITS(192)) u_aes192 (
    .clk(clk), .resetN(resetN), .startValid(sv[1]), .startReady(sr[1]), .keyIn(kin[1][191:0]),
    .busy(bz[1]), .done(dn[1]), .keyReady(kr[1]), .roundIndex(ri[1]), .roundKeyOut(rko[1]));
  key_schedule_engine #(.KEY_BITS(256)) u_aes256 (
    .clk(clk), .resetN(resetN), .startValid(sv[2]), .startReady(sr[2]), .keyIn(kin[2]),
    .busy(bz[2]), .done(dn[2]), .keyReady(kr[2]), .roundIndex(ri[2]), .roundKeyOut(rko[2]));

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  sb    [256];
  logic [31:0] ref_w [3][60];

  typedef struct {
    int           s;
    int           ridx;
    logic [127:0] exp_rk;
    string        nm;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  function automatic int nk_of(input int s);
    return 4 + 2 * s;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic build_ref(input int s, input logic [255:0] key);
    int nk, tw;
    logic [7:0]  rc;
    logic [31:0] t;
    nk = nk_of(s);
    tw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) ref_w[s][i] = key[32*(nk-i)-1 -: 32];
    for (int i = nk; i < tw; i++) begin
      t = ref_w[s][i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      ref_w[s][i] = ref_w[s][i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_rk(input int s, input int r);
    if (r > nk_of(s) + 6) return 128'h0;
    return {ref_w[s][4*r], ref_w[s][4*r+1], ref_w[s][4*r+2], ref_w[s][4*r+3]};
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Only used while the DUT is idle, so crossing clock edges is harmless.
  task automatic read_all(input int s, input string tag, input bit zero);
    for (int r = 0; r < 16; r++) begin
      ri[s] = 4'(r);
      #1;
      check($sformatf("%s_rk%0d", tag, r), rko[s], zero ? 128'h0 : ref_rk(s, r));
    end
  endtask

  task automatic expand(input int s, input logic [255:0] key, input string tag);
    int edges, nk;
    nk = nk_of(s);
    build_ref(s, key);
    @(negedge clk);
    sv[s]  = 1'b1;
    kin[s] = key;
    @(negedge clk);
    sv[s]  = 1'b0;
    kin[s] = rnd256();
    check({tag, "_busy"}, 128'(bz[s]), 128'h1);
    edges = 0;
    while (edges < 200 && !dn[s]) begin
      @(negedge clk);
      edges++;
      // Poke startValid during the expansion; it must not be accepted.
      sv[s]  = (edges < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
      kin[s] = rnd256();
    end
    sv[s] = 1'b0;
    check({tag, "_edges"}, 128'(edges), 128'(4 * (nk + 7) - nk));
    check({tag, "_keyready"}, 128'(kr[s]), 128'h1);
    check({tag, "_startready"}, 128'(sr[s]), 128'h1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 128'(dn[s]), 128'h0);
    read_all(s, tag, 1'b0);
  endtask

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int edges;
    logic [255:0] k2;
    logic [127:0] mid_exp;

    tbl[0] = '{0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "vec128_r10"};
    tbl[1] = '{0, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "vec128_r0"};
    tbl[2] = '{0, 1,  128'ha0fafe1788542cb123a339392a6c7605, "vec128_r1"};
    tbl[3] = '{0, 11, 128'h0, "vec128_r11"};
    tbl[4] = '{1, 12, 128'he98ba06f448c773c8ecc720401002202, "vec192_r12"};
    tbl[5] = '{1, 13, 128'h0, "vec192_r13"};
    tbl[6] = '{2, 14, 128'hfe4890d1e6188d0b046df344706c631e, "vec256_r14"};
    tbl[7] = '{2, 15, 128'h0, "vec256_r15"};

    resetN = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sv[s] = 1'b0; kin[s] = '0; ri[s] = '0;
    end
    build_sbox();
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_startready%0d", s), 128'(sr[s]), 128'h1);
      check($sformatf("reset_busy%0d", s), 128'(bz[s]), 128'h0);
      check($sformatf("reset_done%0d", s), 128'(dn[s]), 128'h0);
      check($sformatf("reset_keyready%0d", s), 128'(kr[s]), 128'h0);
      check($sformatf("reset_rk0_%0d", s), rko[s], 128'h0);
    end

    expand(0, K128, "aes128");
    expand(1, K192, "aes192");
    expand(2, K256, "aes256");

    foreach (tbl[v]) begin
      ri[tbl[v].s] = 4'(tbl[v].ridx);
      #1;
      check(tbl[v].nm, rko[tbl[v].s], tbl[v].exp_rk);
    end

    for (int n = 0; n < 6; n++) begin
      expand(n % 3, rnd256(), $sformatf("rnd%0d", n));
    end

    // Reset in the middle of an AES-128 expansion.
    @(negedge clk);
    sv[0] = 1'b1; kin[0] = K128;
    @(negedge clk);
    sv[0] = 1'b0;
    repeat (20) @(negedge clk);
    ri[0] = 4'd1;
    #1;
`ifdef KEY_SCHED_READ_GUARD_EN
    mid_exp = 128'h0;
`else
    mid_exp = 128'ha0fafe1788542cb123a339392a6c7605;
`endif
    check("mid_expand_rk1", rko[0], mid_exp);
    check("mid_expand_busy", 128'(bz[0]), 128'h1);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    check("midreset_busy", 128'(bz[0]), 128'h0);
    check("midreset_keyready", 128'(kr[0]), 128'h0);
    check("midreset_startready", 128'(sr[0]), 128'h1);
    read_all(0, "midreset", 1'b1);
    expand(0, K128, "after_reset");

    // startValid held high with a changing keyIn; back-to-back second transfer.
    k2 = rnd256();
    build_ref(0, K128 ^ 256'h5a5a);
    @(negedge clk);
    sv[0] = 1'b1; kin[0] = K128 ^ 256'h5a5a;
    @(negedge clk);
    kin[0] = rnd256();
    edges = 0;
    while (edges < 200 && !dn[0]) begin
      @(negedge clk);
      edges++;
      if (!dn[0]) kin[0] = rnd256();
    end
    check("b2b_first_edges", 128'(edges), 128'd40);
    check("b2b_first_keyready", 128'(kr[0]), 128'h1);
    ri[0] = 4'd10;
    #1;
    check("b2b_first_rk10", rko[0], ref_rk(0, 10));
    kin[0] = k2;
    @(negedge clk);
    sv[0] = 1'b0;
    kin[0] = rnd256();
    check("b2b_second_busy", 128'(bz[0]), 128'h1);
    check("b2b_second_keyready", 128'(kr[0]), 128'h0);
    check("b2b_second_done", 128'(dn[0]), 128'h0);
    build_ref(0, k2);
    edges = 0;
    while (edges < 200 && !dn[0]) begin
      @(negedge clk);
      edges++;
    end
    check("b2b_second_edges", 128'(edges), 128'd40);
    @(negedge clk);
    read_all(0, "b2b_second", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
